// File: rtl/key_debouncer.sv
// Per-key two-flop synchroniser plus debounce FSM producing clean levels and press pulses.
// Optional release pulse output is built when KEY_DEBOUNCER_RELEASE_PULSE_EN is defined.
module key_debouncer #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit KEY_ACTIVE_LOW  = 1'b0
) (
    input  logic                clock_50,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press
`ifdef KEY_DEBOUNCER_RELEASE_PULSE_EN
    ,
    output logic [NUM_KEYS-1:0] key_release
`endif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // The cycle that leaves RELEASED/PRESSED already counts as the first stable one.
    localparam logic [CW-1:0] TERM = (DEBOUNCE_CYCLES > 1) ? CW'(DEBOUNCE_CYCLES - 2) : '0;
    localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);
    localparam logic [NUM_KEYS-1:0] IDLE_RAW = {NUM_KEYS{KEY_ACTIVE_LOW}};

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        PRESS_PENDING   = 2'd1,
        PRESSED         = 2'd2,
        RELEASE_PENDING = 2'd3
    } state_t;

    logic [NUM_KEYS-1:0] sync_meta;
    logic [NUM_KEYS-1:0] sync_out;
    logic [NUM_KEYS-1:0] synced;

    // Two-stage synchroniser, reset to the released raw level.
    always_ff @(posedge clock_50) begin
        if (!reset_n) begin
            sync_meta <= IDLE_RAW;
            sync_out  <= IDLE_RAW;
        end else begin
            sync_meta <= key;
            sync_out  <= sync_meta;
        end
    end

    assign synced = sync_out ^ IDLE_RAW;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        state_t          state;
        state_t          state_next;
        logic [CW-1:0]   cnt;
        logic [CW-1:0]   cnt_next;
        logic            level_r;
        logic            level_next;
        logic            press_r;
        logic            press_next;

        // Next-state, counter and output decode for one key.
        always_comb begin
            state_next = state;
            cnt_next   = cnt;
            level_next = level_r;
            press_next = 1'b0;
            case (state)
                RELEASED: begin
                    cnt_next = '0;
                    if (synced[g]) begin
                        if (SINGLE) begin
                            state_next = PRESSED;
                            level_next = 1'b1;
                            press_next = 1'b1;
                        end else begin
                            state_next = PRESS_PENDING;
                        end
                    end else begin
                        state_next = RELEASED;
                    end
                end
                PRESS_PENDING: begin
                    if (!synced[g]) begin
                        state_next = RELEASED;
                        cnt_next   = '0;
                    end else if (cnt == TERM) begin
                        state_next = PRESSED;
                        cnt_next   = '0;
                        level_next = 1'b1;
                        press_next = 1'b1;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                PRESSED: begin
                    cnt_next = '0;
                    if (!synced[g]) begin
                        if (SINGLE) begin
                            state_next = RELEASED;
                            level_next = 1'b0;
                        end else begin
                            state_next = RELEASE_PENDING;
                        end
                    end else begin
                        state_next = PRESSED;
                    end
                end
                RELEASE_PENDING: begin
                    if (synced[g]) begin
                        state_next = PRESSED;
                        cnt_next   = '0;
                    end else if (cnt == TERM) begin
                        state_next = RELEASED;
                        cnt_next   = '0;
                        level_next = 1'b0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                default: begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                    level_next = 1'b0;
                end
            endcase
        end

        // State, counter and registered outputs for one key.
        always_ff @(posedge clock_50) begin
            if (!reset_n) begin
                state   <= RELEASED;
                cnt     <= '0;
                level_r <= 1'b0;
                press_r <= 1'b0;
            end else begin
                state   <= state_next;
                cnt     <= cnt_next;
                level_r <= level_next;
                press_r <= press_next;
            end
        end

        assign key_level[g] = level_r;
        assign key_press[g] = press_r;

`ifdef KEY_DEBOUNCER_RELEASE_PULSE_EN
        logic release_r;

        // Release pulse fires on the edge where the accepted level falls.
        always_ff @(posedge clock_50) begin
            if (!reset_n) begin
                release_r <= 1'b0;
            end else begin
                release_r <= level_r & ~level_next;
            end
        end

        assign key_release[g] = release_r;
`endif
    end

endmodule
